alu_control_mdu: RTL and testbench
==================================

Name: alu_control_mdu

Overview:
- Next-generation ALU control for the rv32i core.
- Decodes the full RV32I integer op set (R-type, I-type ALU, branch compares, load/store, LUI) into a 4-bit ALU_Operation, combinationally.
- Adds an RV32M iterative multiply/divide sequencer (radix-2, XLEN-cycle) that stalls the core while an M-extension op executes.
- Sits between main control/register file and the ALU/writeback mux.

Parameters:
- XLEN, 32, operand/result width; must be even and >= 8.
- CNT_W, $clog2(XLEN), iteration counter width.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid  input  1  instruction in decode is live.
- kill  input  1  synchronous abort of an in-flight M op (pipeline flush).
- instruction_funct3  input  3  instr[14:12].
- instruction_funct7  input  7  instr[31:25].
- ALUOp  input  3  000 load/store, 001 branch, 010 R-type, 011 I-type ALU, 100 LUI.
- rs1_data  input  XLEN  operand A.
- rs2_data  input  XLEN  operand B.
- ALU_Operation  output  4  ALU op select.
- illegal  output  1  unsupported funct encoding.
- stall  output  1  hold PC and pipeline.
- mdu_done  output  1  mdu_result valid this cycle.
- mdu_result  output  XLEN  M-op result.

Behaviour:
- Clock and reset: one clock; rst asynchronous active-high. Reset values: state=IDLE, mdu_done=0, mdu_result=0, counter=0. Reset mid-operation aborts silently; no done pulse.
- ALU_Operation encodings: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001, PASSB 1010.
- ALU_Operation decode is combinational; it does not depend on state.
  - 000 -> ADD.
  - 100 -> PASSB.
  - 001 -> BEQ/BNE SUB; BLT/BGE SLT; BLTU/BGEU SLTU; funct3 010/011 -> illegal.
  - 010 with funct7=0000000 -> standard R map by funct3.
  - 010 with funct7=0100000 -> SUB for funct3 000, SRA for 101, otherwise illegal.
  - 011 -> ADDI..ANDI by funct3. SRAI when funct7=0100000 and funct3=101. Slli/srli/srai with any other funct7 bits set -> illegal.
  - Any other ALUOp or funct7 -> illegal=1, ALU_Operation=ADD (never X).
- M op detection: m_req = valid & ALUOp==010 & funct7==0000001. Ops by funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE: stall = m_req (combinational). On m_req, capture operand magnitudes, result-sign flags and op, then go to CALC with counter=0.
  - IDLE, divide-by-zero (rs2_data==0, div/rem): go straight to DONE.
    - DIV/DIVU result = all ones.
    - REM/REMU result = rs1_data.
  - CALC: stall=1. One shift-add (mul) or restoring subtract (div) step per cycle, 2*XLEN-bit accumulator. Go to FIX after counter==XLEN-1.
  - FIX: stall=1. Apply sign correction; select low/high half or quotient/remainder into mdu_result. Go to DONE.
  - DONE: stall=0, mdu_done=1 for exactly one cycle; mdu_result holds until the next capture. Go to IDLE. valid/m_req is ignored in DONE, because the retiring instruction is the same one.
- Latency: m_req first seen in cycle T. stall is high T..T+XLEN+1 (XLEN+2 cycles); mdu_done in T+XLEN+2. Divide-by-zero: stall high in T only; done in T+1.
- Signed rules:
  - Quotient sign = sign(A) xor sign(B).
  - Remainder sign = sign(A).
  - MULHSU treats rs2 as unsigned.
  - Overflow MIN/-1 -> DIV=MIN, REM=0, which falls out of the magnitude algorithm.
- kill: synchronous, highest priority after rst. In CALC/FIX -> IDLE, no done, mdu_result unchanged. In IDLE it also suppresses capture.
- Non-M instructions never affect FSM state.

Test Plan:
- Decode sweep: every legal ALUOp/funct3/funct7 combination -> expected ALU_Operation, illegal=0. Example: ALUOp=011, funct3=101, funct7=0100000 -> 0111. ALUOp=001, funct3=010 -> illegal=1, ALU_Operation=0010.
- MUL/MULH, XLEN=32: rs1=0xFFFFFFFF (-1), rs2=7.
  - MUL -> 0xFFFFFFF9; MULH -> 0xFFFFFFFF; MULHU -> 0x00000006.
  - stall high for exactly 34 cycles, mdu_done on cycle 35.
- DIV/REM signs: rs1=-7 (0xFFFFFFF9), rs2=2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF. DIVU -> 0x7FFFFFFC.
- Corner cases:
  - rs2=0: DIV -> 0xFFFFFFFF, REM -> rs1; done 1 cycle after request.
  - rs1=0x80000000, rs2=0xFFFFFFFF: DIV -> 0x80000000, REM -> 0.
- Abort:
  - kill at cycle T+10 of a DIV -> stall=0 next cycle, no mdu_done, mdu_result unchanged.
  - rst asserted asynchronously mid-CALC -> all outputs at reset values immediately.
- Back-to-back: MUL followed directly by MULHU -> two mdu_done pulses 35 cycles apart, with no capture during either DONE cycle.

Source files
------------

// File: rtl/alu_control_mdu.sv
// alu_control_mdu
//   Combinational RV32I ALU-operation decoder plus an iterative RV32M
//   multiply/divide sequencer (radix-2, one step per cycle) that stalls the
//   core while an M-extension instruction executes.
//
// Ports
//   clk, rst            core clock (rising edge), asynchronous active-high reset
//   valid               instruction in decode is live
//   kill                synchronous abort of an in-flight M op (pipeline flush)
//   instruction_funct3  instr[14:12]
//   instruction_funct7  instr[31:25]
//   ALUOp               000 ld/st, 001 branch, 010 R-type, 011 I-type ALU, 100 LUI
//   rs1_data, rs2_data  operands A and B
//   ALU_Operation       4-bit ALU op select
//   illegal             unsupported funct encoding
//   stall               hold PC and pipeline
//   mdu_done            mdu_result valid this cycle
//   mdu_result          M-op result (holds until the next result is written)
module alu_control_mdu #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid,
   input  logic            kill,
   input  logic [2:0]      instruction_funct3,
   input  logic [6:0]      instruction_funct7,
   input  logic [2:0]      ALUOp,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic [3:0]      ALU_Operation,
   output logic            illegal,
   output logic            stall,
   output logic            mdu_done,
   output logic [XLEN-1:0] mdu_result
);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_SLL   = 4'b0100;
   localparam logic [3:0] OP_SRL   = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SRA   = 4'b0111;
   localparam logic [3:0] OP_SLT   = 4'b1000;
   localparam logic [3:0] OP_SLTU  = 4'b1001;
   localparam logic [3:0] OP_PASSB = 4'b1010;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MUL  = 7'b0000001;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

   // ------------------------------------------------------------------
   // ALU operation decode (independent of sequencer state)
   // ------------------------------------------------------------------
   always_comb begin
      ALU_Operation = OP_ADD;
      illegal       = 1'b0;
      case (ALUOp)
         3'b000: ALU_Operation = OP_ADD;
         3'b100: ALU_Operation = OP_PASSB;
         3'b001: begin
            case (instruction_funct3)
               3'b000, 3'b001: ALU_Operation = OP_SUB;
               3'b100, 3'b101: ALU_Operation = OP_SLT;
               3'b110, 3'b111: ALU_Operation = OP_SLTU;
               default:        illegal = 1'b1;
            endcase
         end
         3'b010: begin
            if (instruction_funct7 == F7_BASE) begin
               case (instruction_funct3)
                  3'b000:  ALU_Operation = OP_ADD;
                  3'b001:  ALU_Operation = OP_SLL;
                  3'b010:  ALU_Operation = OP_SLT;
                  3'b011:  ALU_Operation = OP_SLTU;
                  3'b100:  ALU_Operation = OP_XOR;
                  3'b101:  ALU_Operation = OP_SRL;
                  3'b110:  ALU_Operation = OP_OR;
                  default: ALU_Operation = OP_AND;
               endcase
            end else if (instruction_funct7 == F7_ALT) begin
               case (instruction_funct3)
                  3'b000:  ALU_Operation = OP_SUB;
                  3'b101:  ALU_Operation = OP_SRA;
                  default: illegal = 1'b1;
               endcase
            end else if (instruction_funct7 != F7_MUL) begin
               // M-extension ops are legal; their result comes from the MDU.
               illegal = 1'b1;
            end
         end
         3'b011: begin
            // funct7 is immediate bits except for the shift-immediates.
            case (instruction_funct3)
               3'b000: ALU_Operation = OP_ADD;
               3'b010: ALU_Operation = OP_SLT;
               3'b011: ALU_Operation = OP_SLTU;
               3'b100: ALU_Operation = OP_XOR;
               3'b110: ALU_Operation = OP_OR;
               3'b111: ALU_Operation = OP_AND;
               3'b001: begin
                  if (instruction_funct7 == F7_BASE) ALU_Operation = OP_SLL;
                  else                               illegal = 1'b1;
               end
               default: begin
                  if (instruction_funct7 == F7_BASE)     ALU_Operation = OP_SRL;
                  else if (instruction_funct7 == F7_ALT) ALU_Operation = OP_SRA;
                  else                                   illegal = 1'b1;
               end
            endcase
         end
         default: illegal = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------
   // Multiply / divide sequencer
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t              state, state_next;
   logic [CNT_W-1:0]    counter;
   logic [2:0]          op;
   logic [XLEN-1:0]     opnd;       // multiplicand (mul) or divisor (div) magnitude
   logic [2*XLEN-1:0]   acc;        // {high, low}: product, or {remainder, quotient}
   logic                neg_q;      // product / quotient sign
   logic                neg_r;      // remainder sign

   logic                m_req, capture, div_zero, a_signed, b_signed, sa, sb;
   logic [XLEN-1:0]     a_mag_in, b_mag_in;

   assign m_req    = valid && (ALUOp == 3'b010) && (instruction_funct7 == F7_MUL);
   assign capture  = (state == IDLE) && m_req && !kill;
   assign div_zero = instruction_funct3[2] && (rs2_data == '0);

   // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM.
   assign a_signed = (instruction_funct3 == 3'b001) || (instruction_funct3 == 3'b010) ||
                     (instruction_funct3 == 3'b100) || (instruction_funct3 == 3'b110);
   assign b_signed = (instruction_funct3 == 3'b001) || (instruction_funct3 == 3'b100) ||
                     (instruction_funct3 == 3'b110);
   assign sa       = a_signed && rs1_data[XLEN-1];
   assign sb       = b_signed && rs2_data[XLEN-1];
   // MIN stays MIN as an unsigned magnitude, which makes MIN/-1 come out right.
   assign a_mag_in = sa ? (~rs1_data + 1'b1) : rs1_data;
   assign b_mag_in = sb ? (~rs2_data + 1'b1) : rs2_data;

   // Shift-add step: add multiplicand into the high half when the
   // multiplier LSB is set, then shift the whole accumulator right.
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_step;
   assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
   assign mul_step = {mul_sum, acc[XLEN-1:1]};

   // Restoring divide step: shift left, trial-subtract the divisor.
   logic [XLEN:0]     rem_sh, div_diff;
   logic [2*XLEN-1:0] div_step;
   assign rem_sh   = acc[2*XLEN-1:XLEN-1];
   assign div_diff = rem_sh - {1'b0, opnd};
   assign div_step = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

   // Sign correction and half / quotient-remainder selection.
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, fix_result;
   assign prod = neg_q ? (~acc + 1'b1) : acc;
   assign quo  = neg_q ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
   assign rem  = neg_r ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];

   always_comb begin
      fix_result = '0;
      if (op[2])              fix_result = op[1] ? rem : quo;
      else if (op[1:0] == 2'b00) fix_result = prod[XLEN-1:0];
      else                    fix_result = prod[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_next = state;
      stall      = 1'b0;
      mdu_done   = 1'b0;
      case (state)
         IDLE: begin
            stall = m_req && !kill;
            if (capture) state_next = div_zero ? DONE : CALC;
         end
         CALC: begin
            stall = 1'b1;
            if (kill)                      state_next = IDLE;
            else if (counter == LAST_STEP) state_next = FIX;
         end
         FIX: begin
            stall      = 1'b1;
            state_next = kill ? IDLE : DONE;
         end
         DONE: begin
            // The instruction still in decode is the one retiring; no capture.
            mdu_done   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         counter    <= '0;
         op         <= '0;
         opnd       <= '0;
         acc        <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         mdu_result <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (capture) begin
                  op      <= instruction_funct3;
                  opnd    <= instruction_funct3[2] ? b_mag_in : a_mag_in;
                  acc     <= {{XLEN{1'b0}}, (instruction_funct3[2] ? a_mag_in : b_mag_in)};
                  neg_q   <= sa ^ sb;
                  neg_r   <= sa;
                  counter <= '0;
                  if (div_zero) mdu_result <= instruction_funct3[1] ? rs1_data : '1;
               end
            end
            CALC: begin
               if (!kill) begin
                  acc     <= op[2] ? div_step : mul_step;
                  counter <= counter + 1'b1;
               end
            end
            FIX: begin
               if (!kill) mdu_result <= fix_result;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_control_mdu.sv
// tb_alu_control_mdu
//   Directed testbench for alu_control_mdu (XLEN=32): decode table, M-op
//   results and latency, divide-by-zero, overflow, kill, async reset and
//   back-to-back operation.
module tb_alu_control_mdu;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic        kill;
   logic [2:0]  instruction_funct3;
   logic [6:0]  instruction_funct7;
   logic [2:0]  ALUOp;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [3:0]  ALU_Operation;
   logic        illegal;
   logic        stall;
   logic        mdu_done;
   logic [31:0] mdu_result;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int cyc       = 0;
   int last_done_cyc;
   logic [31:0] last_result;

   alu_control_mdu #(.XLEN(32)) dut (
      .clk                (clk),
      .rst                (rst),
      .valid              (valid),
      .kill               (kill),
      .instruction_funct3 (instruction_funct3),
      .instruction_funct7 (instruction_funct7),
      .ALUOp              (ALUOp),
      .rs1_data           (rs1_data),
      .rs2_data           (rs2_data),
      .ALU_Operation      (ALU_Operation),
      .illegal            (illegal),
      .stall              (stall),
      .mdu_done           (mdu_done),
      .mdu_result         (mdu_result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // {ALUOp, funct3, funct7, expected ALU_Operation, expected illegal}
   localparam int NDEC = 38;
   localparam logic [17:0] DEC_VEC [NDEC] = '{
      {3'b000, 3'b000, 7'h00, 4'h2, 1'b0},
      {3'b000, 3'b111, 7'h7f, 4'h2, 1'b0},
      {3'b100, 3'b011, 7'h12, 4'ha, 1'b0},
      {3'b001, 3'b000, 7'h00, 4'h6, 1'b0},
      {3'b001, 3'b001, 7'h00, 4'h6, 1'b0},
      {3'b001, 3'b100, 7'h00, 4'h8, 1'b0},
      {3'b001, 3'b101, 7'h00, 4'h8, 1'b0},
      {3'b001, 3'b110, 7'h00, 4'h9, 1'b0},
      {3'b001, 3'b111, 7'h00, 4'h9, 1'b0},
      {3'b001, 3'b010, 7'h00, 4'h2, 1'b1},
      {3'b001, 3'b011, 7'h00, 4'h2, 1'b1},
      {3'b010, 3'b000, 7'h00, 4'h2, 1'b0},
      {3'b010, 3'b001, 7'h00, 4'h4, 1'b0},
      {3'b010, 3'b010, 7'h00, 4'h8, 1'b0},
      {3'b010, 3'b011, 7'h00, 4'h9, 1'b0},
      {3'b010, 3'b100, 7'h00, 4'h3, 1'b0},
      {3'b010, 3'b101, 7'h00, 4'h5, 1'b0},
      {3'b010, 3'b110, 7'h00, 4'h1, 1'b0},
      {3'b010, 3'b111, 7'h00, 4'h0, 1'b0},
      {3'b010, 3'b000, 7'h20, 4'h6, 1'b0},
      {3'b010, 3'b101, 7'h20, 4'h7, 1'b0},
      {3'b010, 3'b001, 7'h20, 4'h2, 1'b1},
      {3'b010, 3'b111, 7'h20, 4'h2, 1'b1},
      {3'b010, 3'b000, 7'h01, 4'h2, 1'b0},
      {3'b010, 3'b000, 7'h10, 4'h2, 1'b1},
      {3'b011, 3'b000, 7'h55, 4'h2, 1'b0},
      {3'b011, 3'b010, 7'h00, 4'h8, 1'b0},
      {3'b011, 3'b011, 7'h7f, 4'h9, 1'b0},
      {3'b011, 3'b100, 7'h00, 4'h3, 1'b0},
      {3'b011, 3'b110, 7'h00, 4'h1, 1'b0},
      {3'b011, 3'b111, 7'h00, 4'h0, 1'b0},
      {3'b011, 3'b001, 7'h00, 4'h4, 1'b0},
      {3'b011, 3'b001, 7'h20, 4'h2, 1'b1},
      {3'b011, 3'b101, 7'h00, 4'h5, 1'b0},
      {3'b011, 3'b101, 7'h20, 4'h7, 1'b0},
      {3'b011, 3'b101, 7'h01, 4'h2, 1'b1},
      {3'b101, 3'b000, 7'h00, 4'h2, 1'b1},
      {3'b111, 3'b000, 7'h00, 4'h2, 1'b1}
   };

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one M op in the current (IDLE) cycle and follow it to its done
   // pulse. Returns while the DUT is in the DONE cycle.
   task automatic run_m(input string name, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_stall,
                        input int exp_done);
      int done_n = -1;
      int stall_cnt = 0;
      valid = 1'b1; kill = 1'b0; ALUOp = 3'b010; instruction_funct7 = 7'h01;
      instruction_funct3 = f3; rs1_data = a; rs2_data = b;
      for (int n = 0; n < 100; n++) begin
         #1;
         if (mdu_done) begin
            done_n = n;
            break;
         end
         if (stall) stall_cnt++;
         tick();
      end
      last_done_cyc = cyc;
      $display("%s a=%h b=%h result=%h stall_cycles=%0d done_at=%0d",
               name, a, b, mdu_result, stall_cnt, done_n);
      total_cnt++;
      if (done_n !== exp_done)
         $display("FAIL %s done_cycle: got %0d expected %0d", name, done_n, exp_done);
      else pass_cnt++;
      total_cnt++;
      if (stall_cnt !== exp_stall)
         $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cnt, exp_stall);
      else pass_cnt++;
      total_cnt++;
      if (mdu_result !== exp)
         $display("FAIL %s result: got %h expected %h", name, mdu_result, exp);
      else pass_cnt++;
      total_cnt++;
      if (stall !== 1'b0)
         $display("FAIL %s stall_in_done: got %b expected 0", name, stall);
      else pass_cnt++;
      last_result = exp;
   endtask

   // Move past the DONE cycle with the instruction retired.
   task automatic retire(input string name);
      tick();
      valid = 1'b0;
      #1;
      total_cnt++;
      if (mdu_done !== 1'b0 || stall !== 1'b0)
         $display("FAIL %s after_done: got done=%b stall=%b expected 0/0", name, mdu_done, stall);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b1; valid = 1'b0; kill = 1'b0; ALUOp = 3'b000;
      instruction_funct3 = 3'b000; instruction_funct7 = 7'h00;
      rs1_data = '0; rs2_data = '0; last_result = '0;
      tick(); tick();
      total_cnt++;
      if (mdu_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", mdu_done);
      else pass_cnt++;
      total_cnt++;
      if (mdu_result !== 32'h0) $display("FAIL reset_result: got %h expected 0", mdu_result);
      else pass_cnt++;
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall);
      else pass_cnt++;
      rst = 1'b0;
      tick();
      $display("reset checked");
   endtask

   task automatic test_decode();
      logic [17:0] v;
      logic [4:0]  got;
      valid = 1'b0;
      for (int i = 0; i < NDEC; i++) begin
         v = DEC_VEC[i];
         ALUOp = v[17:15]; instruction_funct3 = v[14:12]; instruction_funct7 = v[11:5];
         #1;
         got = {ALU_Operation, illegal};
         $display("decode aluop=%b f3=%b f7=%b -> op=%b illegal=%b",
                  v[17:15], v[14:12], v[11:5], ALU_Operation, illegal);
         total_cnt++;
         if (got !== v[4:0])
            $display("FAIL decode_%0d: got op=%b ill=%b expected op=%b ill=%b",
                     i, got[4:1], got[0], v[4:1], v[0]);
         else pass_cnt++;
      end
      tick();
   endtask

   task automatic test_mul();
      run_m("MUL",    3'b000, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFF9, 34, 34); retire("MUL");
      run_m("MULH",   3'b001, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFF, 34, 34); retire("MULH");
      run_m("MULHU",  3'b011, 32'hFFFFFFFF, 32'd7, 32'h00000006, 34, 34); retire("MULHU");
      run_m("MULHSU", 3'b010, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFF, 34, 34); retire("MULHSU");
      run_m("MUL2",   3'b000, 32'd12345,    32'd1000, 32'd12345000, 34, 34); retire("MUL2");
   endtask

   task automatic test_div();
      run_m("DIV",  3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, 34); retire("DIV");
      run_m("REM",  3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, 34); retire("REM");
      run_m("REMU", 3'b111, 32'hFFFFFFF9, 32'd2, 32'h00000001, 34, 34); retire("REMU");
      run_m("DIVU", 3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 34, 34); retire("DIVU");
   endtask

   task automatic test_kill();
      logic seen_done = 1'b0;
      valid = 1'b1; kill = 1'b0; ALUOp = 3'b010; instruction_funct7 = 7'h01;
      instruction_funct3 = 3'b100; rs1_data = 32'd100; rs2_data = 32'd3;
      for (int n = 0; n < 10; n++) tick();
      kill = 1'b1; valid = 1'b0;
      #1;
      total_cnt++;
      if (stall !== 1'b1) $display("FAIL kill_stall_in_calc: got %b expected 1", stall);
      else pass_cnt++;
      tick();
      kill = 1'b0;
      #1;
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL kill_stall_after: got %b expected 0", stall);
      else pass_cnt++;
      total_cnt++;
      if (mdu_result !== last_result)
         $display("FAIL kill_result: got %h expected %h", mdu_result, last_result);
      else pass_cnt++;
      for (int n = 0; n < 40; n++) begin
         if (mdu_done) seen_done = 1'b1;
         tick();
      end
      total_cnt++;
      if (seen_done !== 1'b0) $display("FAIL kill_no_done: got %b expected 0", seen_done);
      else pass_cnt++;
      $display("kill DIV at T+10 checked result=%h", mdu_result);
   endtask

   task automatic test_corners();
      run_m("DIV0",  3'b100, 32'h12345678, 32'h0, 32'hFFFFFFFF, 1, 1); retire("DIV0");
      run_m("REM0",  3'b110, 32'h12345678, 32'h0, 32'h12345678, 1, 1); retire("REM0");
      run_m("DIVU0", 3'b101, 32'hCAFEF00D, 32'h0, 32'hFFFFFFFF, 1, 1); retire("DIVU0");
      run_m("DIVOV", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, 34); retire("DIVOV");
      run_m("REMOV", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34, 34); retire("REMOV");
   endtask

   task automatic test_back_to_back();
      int first_done;
      run_m("B2B_MUL", 3'b000, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFF9, 34, 34);
      first_done = last_done_cyc;
      tick();
      run_m("B2B_MULHU", 3'b011, 32'hFFFFFFFF, 32'd7, 32'h00000006, 34, 34);
      total_cnt++;
      if (last_done_cyc - first_done !== 35)
         $display("FAIL b2b_spacing: got %0d expected 35", last_done_cyc - first_done);
      else pass_cnt++;
      retire("B2B");
   endtask

   task automatic test_async_reset();
      valid = 1'b1; kill = 1'b0; ALUOp = 3'b010; instruction_funct7 = 7'h01;
      instruction_funct3 = 3'b000; rs1_data = 32'd9; rs2_data = 32'd9;
      for (int n = 0; n < 6; n++) tick();
      #2;
      rst = 1'b1; valid = 1'b0;
      #1;
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL areset_stall: got %b expected 0", stall);
      else pass_cnt++;
      total_cnt++;
      if (mdu_done !== 1'b0) $display("FAIL areset_done: got %b expected 0", mdu_done);
      else pass_cnt++;
      total_cnt++;
      if (mdu_result !== 32'h0) $display("FAIL areset_result: got %h expected 0", mdu_result);
      else pass_cnt++;
      tick();
      rst = 1'b0;
      tick();
      $display("async reset mid-CALC checked");
      run_m("POSTRST_MULHU", 3'b011, 32'h80000000, 32'h4, 32'h00000002, 34, 34);
      retire("POSTRST");
   endtask

   initial begin
      test_reset();
      test_decode();
      test_mul();
      test_div();
      test_kill();
      test_corners();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
